// File: rtl/incrementer_counter4bit.sv
// ============================================================================
// incrementer_counter4bit
// ----------------------------------------------------------------------------
// A 4-bit synchronous up-counter that wraps modulo (MAX_COUNT + 1). Its
// next-state datapath is built from gate-level primitives. A ripple
// incrementer (a half-adder chain with carry-in tied to 1) produces q+1. A
// chain of per-bit 2:1 muxes then picks between 0, q+1, q and din.
// This is the counting-up counterpart of the 4-bit decrement datapath.
//
// Every gate model in this file reduces to a single 2-input NAND.
// The hierarchy is therefore uniform, and checkers can bind to any level.
//
// Modules in this file (leaf first):
//   nand2_g            2-input NAND, the only primitive
//   inv_g              inverter (NAND with both inputs tied)
//   and2_g             AND  = NAND + INV
//   or2_g              OR   = NAND of inverted inputs
//   xor2_g             XOR  = classic 4-NAND structure
//   mux2_g             1-bit 2:1 mux from NANDs (s=0 -> a, s=1 -> b)
//   half_adder_g       s = a ^ b, co = a & b
//   incr4_g            4-bit ripple incrementer, carry-in = 1
//   mux2x4_g           4-bit 2:1 mux, one mux2_g per bit
//   incrementer_counter4bit  top level
//
// Top-level ports:
//   clk   in   1  rising-edge clock
//   rst   in   1  synchronous active-high reset (q <= 0, ovf <= 0)
//   en    in   1  count enable
//   load  in   1  synchronous parallel load (beats en)
//   din   in   4  load value; values above MAX_COUNT are kept as-is
//   q     out  4  registered count
//   tc    out  1  combinational terminal count: en & (q >= MAX_COUNT)
//   ovf   out  1  registered wrap pulse, high in the cycle after a wrap
//
// Edge priority: rst > load > en > hold.
// ============================================================================

// ----------------------------------------------------------------------------
// nand2_g: y = ~(a & b)
// ----------------------------------------------------------------------------
module nand2_g (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// ----------------------------------------------------------------------------
// inv_g: y = ~a
// ----------------------------------------------------------------------------
module inv_g (
    input  logic a,
    output logic y
);
    nand2_g u_nand (.a(a), .b(a), .y(y));
endmodule

// ----------------------------------------------------------------------------
// and2_g: y = a & b
// ----------------------------------------------------------------------------
module and2_g (
    input  logic a,
    input  logic b,
    output logic y
);
    logic n;

    nand2_g u_nand (.a(a), .b(b), .y(n));
    inv_g   u_inv  (.a(n), .y(y));
endmodule

// ----------------------------------------------------------------------------
// or2_g: y = a | b   (De Morgan: ~(~a & ~b))
// ----------------------------------------------------------------------------
module or2_g (
    input  logic a,
    input  logic b,
    output logic y
);
    logic an;
    logic bn;

    inv_g   u_inv_a (.a(a),  .y(an));
    inv_g   u_inv_b (.a(b),  .y(bn));
    nand2_g u_nand  (.a(an), .b(bn), .y(y));
endmodule

// ----------------------------------------------------------------------------
// xor2_g: y = a ^ b
// This is the four-NAND form. The shared first NAND feeds both side NANDs.
// ----------------------------------------------------------------------------
module xor2_g (
    input  logic a,
    input  logic b,
    output logic y
);
    logic nab;
    logic na;
    logic nb;

    nand2_g u_n0 (.a(a),   .b(b),   .y(nab));
    nand2_g u_n1 (.a(a),   .b(nab), .y(na));
    nand2_g u_n2 (.a(b),   .b(nab), .y(nb));
    nand2_g u_n3 (.a(na),  .b(nb),  .y(y));
endmodule

// ----------------------------------------------------------------------------
// mux2_g: y = s ? b : a
// The NAND-NAND sum-of-products form is y = ~(~(a & ~s) & ~(b & s)).
// ----------------------------------------------------------------------------
module mux2_g (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    logic sn;
    logic pa;
    logic pb;

    inv_g   u_inv (.a(s),  .y(sn));
    nand2_g u_na  (.a(a),  .b(sn), .y(pa));
    nand2_g u_nb  (.a(b),  .b(s),  .y(pb));
    nand2_g u_no  (.a(pa), .b(pb), .y(y));
endmodule

// ----------------------------------------------------------------------------
// half_adder_g: s = a ^ b, co = a & b
// ----------------------------------------------------------------------------
module half_adder_g (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    xor2_g u_xor (.a(a), .b(b), .y(s));
    and2_g u_and (.a(a), .b(b), .y(co));
endmodule

// ----------------------------------------------------------------------------
// incr4_g: {cout, sum} = a + 1
// This is a ripple chain of half adders. The carry into bit 0 is tied high,
// so sum[i] = a[i] ^ c[i] and c[i+1] = a[i] & c[i].
// cout is high only when a is all ones.
// ----------------------------------------------------------------------------
module incr4_g (
    input  logic [3:0] a,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < 4; i++) begin : g_ha
        half_adder_g u_ha (
            .a  (a[i]),
            .b  (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[4];
endmodule

// ----------------------------------------------------------------------------
// mux2x4_g: 4-bit 2:1 mux, y = s ? b : a, one gate-level mux per bit
// ----------------------------------------------------------------------------
module mux2x4_g (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       s,
    output logic [3:0] y
);
    for (genvar i = 0; i < 4; i++) begin : g_bit
        mux2_g u_mux (
            .a (a[i]),
            .b (b[i]),
            .s (s),
            .y (y[i])
        );
    end
endmodule

// ----------------------------------------------------------------------------
// incrementer_counter4bit: loadable, cascadable modulo counter
//
// The next-state datapath is a chain of three 4-bit 2:1 muxes, lowest
// priority first:
//   cnt_next  = wrap ? 4'h0 : q+1   (wrap or increment)
//   step_next = en   ? cnt_next : q (count or hold)
//   q_next    = load ? din : step_next
// Reset has the highest priority and is applied in the register process.
// din reaches q only through the register, so no combinational path exists
// from din to q.
//
// wrap is "q >= MAX_COUNT", not "q == MAX_COUNT". A loaded value above the
// terminal value therefore wraps to 0 on the next enabled edge instead of
// counting further.
// ----------------------------------------------------------------------------
module incrementer_counter4bit #(
    parameter int MAX_COUNT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] din,
    output logic [3:0] q,
    output logic       tc,
    output logic       ovf
);
    localparam logic [3:0] MAX_Q = 4'(MAX_COUNT);

    logic [3:0] inc_q;      // q + 1 from the ripple incrementer
    logic       inc_cout;   // carry out of bit 3, not part of the count
    logic       wrap;       // q is at or past the terminal value
    logic [3:0] cnt_next;   // value taken on an enabled edge
    logic [3:0] step_next;  // count-or-hold
    logic [3:0] q_next;     // after load selection
    logic       ovf_cnt;    // ovf for the count-or-hold path
    logic       ovf_next;   // after load selection (load clears ovf)

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    incr4_g u_incr (
        .a    (q),
        .sum  (inc_q),
        .cout (inc_cout)
    );

    assign wrap = (q >= MAX_Q);

    mux2x4_g u_mux_wrap (
        .a (inc_q),
        .b (4'h0),
        .s (wrap),
        .y (cnt_next)
    );

    mux2x4_g u_mux_en (
        .a (q),
        .b (cnt_next),
        .s (en),
        .y (step_next)
    );

    mux2x4_g u_mux_load (
        .a (step_next),
        .b (din),
        .s (load),
        .y (q_next)
    );

    // ovf follows the same priority as q.
    // It is set by an enabled wrap and cleared by an enabled non-wrap or by
    // a load. It holds when neither en nor load is high.
    mux2_g u_mux_ovf_en (
        .a (ovf),
        .b (wrap),
        .s (en),
        .y (ovf_cnt)
    );

    mux2_g u_mux_ovf_load (
        .a (ovf_cnt),
        .b (1'b0),
        .s (load),
        .y (ovf_next)
    );

    // Terminal count for cascading. It is combinational, so the next stage
    // sees its enable in the same cycle that this stage sits at its last
    // value.
    and2_g u_and_tc (
        .a (en),
        .b (wrap),
        .y (tc)
    );

    // ------------------------------------------------------------------
    // State register with synchronous reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= 4'h0;
            ovf <= 1'b0;
        end else begin
            q   <= q_next;
            ovf <= ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Simulation-only consistency checks
    // ------------------------------------------------------------------
    // The incrementer carry-out fires exactly when q is all ones. With
    // MAX_COUNT = 15 this is also the wrap condition.
    a_cout_all_ones : assert property (@(posedge clk) inc_cout == (q == 4'hF));

    // MAX_COUNT must fit the 4-bit count and leave at least two states.
    a_max_range : assert property (@(posedge clk) (MAX_COUNT >= 1) && (MAX_COUNT <= 15));

endmodule

// File: tb/tb_incrementer_counter4bit.sv
// ============================================================================
// tb_incrementer_counter4bit
// ----------------------------------------------------------------------------
// Five counter instances:
//   u15    MAX_COUNT=15 and u9 MAX_COUNT=9 share rst/en/load/din and are
//          driven from one table of directed vectors
//   u1     MAX_COUNT=1, its own enable, for the every-other-cycle ovf case
//   u_lo / u_hi  MAX_COUNT=15 cascade (tc of low stage drives en of high)
// Inputs change on the falling edge. tc is sampled before the rising edge,
// and q/ovf are sampled 1 time unit after it.
// ============================================================================
module tb_incrementer_counter4bit;

    // ------------------------------------------------------------------
    // Clock and shared reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic       en;
    logic       load;
    logic [3:0] din;
    logic [3:0] q15, q9;
    logic       tc15, tc9, ovf15, ovf9;

    logic       en1;
    logic [3:0] q1;
    logic       tc1, ovf1;

    logic       casc_en;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, ovf_lo, ovf_hi;

    incrementer_counter4bit #(.MAX_COUNT(15)) u15 (
        .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
        .q(q15), .tc(tc15), .ovf(ovf15)
    );

    incrementer_counter4bit #(.MAX_COUNT(9)) u9 (
        .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
        .q(q9), .tc(tc9), .ovf(ovf9)
    );

    incrementer_counter4bit #(.MAX_COUNT(1)) u1 (
        .clk(clk), .rst(rst), .en(en1), .load(1'b0), .din(4'h0),
        .q(q1), .tc(tc1), .ovf(ovf1)
    );

    incrementer_counter4bit #(.MAX_COUNT(15)) u_lo (
        .clk(clk), .rst(rst), .en(casc_en), .load(1'b0), .din(4'h0),
        .q(q_lo), .tc(tc_lo), .ovf(ovf_lo)
    );

    incrementer_counter4bit #(.MAX_COUNT(15)) u_hi (
        .clk(clk), .rst(rst), .en(tc_lo), .load(1'b0), .din(4'h0),
        .q(q_hi), .tc(tc_hi), .ovf(ovf_hi)
    );

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table for u15/u9
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [3:0] din;
        logic       chk_tc;   // tc compared before the edge
        logic       tc15;
        logic       tc9;
        logic [3:0] q15;      // after the edge
        logic [3:0] q9;
        logic       ovf15;
        logic       ovf9;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(
        input logic r, input logic e, input logic l, input logic [3:0] d,
        input logic ct, input logic t15, input logic t9,
        input logic [3:0] a15, input logic [3:0] a9,
        input logic o15, input logic o9);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.din = d;
        v.chk_tc = ct; v.tc15 = t15; v.tc9 = t9;
        v.q15 = a15; v.q9 = a9; v.ovf15 = o15; v.ovf9 = o9;
        vecs.push_back(v);
    endfunction

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic drive(input logic r, input logic e, input logic l, input logic [3:0] d);
        @(negedge clk);
        rst  = r;
        en   = e;
        load = l;
        din  = d;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int b15;
        int b9;
        logic [7:0] exp_v;
        int hi_pulses;

        rst = 1'b1; en = 1'b0; load = 1'b0; din = 4'h0;
        en1 = 1'b0; casc_en = 1'b0;

        // Reset for two edges while en/load/din try to move the count.
        add_vec(1, 1, 1, 4'hA, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        add_vec(1, 1, 1, 4'hA, 1, 0, 0, 4'h0, 4'h0, 0, 0);
        // 17 enabled edges from 0. u15 runs 0..15,0,1 and u9 wraps at 9.
        for (int i = 0; i < 17; i++) begin
            b15 = i % 16;
            b9  = i % 10;
            add_vec(0, 1, 0, 4'h0, 1, b15 == 15, b9 == 9,
                    4'((i + 1) % 16), 4'((i + 1) % 10), b15 == 15, b9 == 9);
        end
        // Load 0xC with en low. u9 (above its max) then wraps to 0 with ovf.
        add_vec(0, 0, 1, 4'hC, 1, 0, 0, 4'hC, 4'hC, 0, 0);
        add_vec(0, 1, 0, 4'h0, 1, 0, 1, 4'hD, 4'h0, 0, 1);
        add_vec(0, 1, 0, 4'h0, 1, 0, 0, 4'hE, 4'h1, 0, 0);
        // Reset mid-count at q15=14, then the next enabled edge gives 1.
        add_vec(1, 1, 0, 4'h0, 1, 0, 0, 4'h0, 4'h0, 0, 0);
        add_vec(0, 1, 0, 4'h0, 1, 0, 0, 4'h1, 4'h1, 0, 0);
        add_vec(0, 1, 0, 4'h0, 1, 0, 0, 4'h2, 4'h2, 0, 0);
        add_vec(0, 1, 0, 4'h0, 1, 0, 0, 4'h3, 4'h3, 0, 0);
        // At q=3, load beats en: q=7. Then hold for 5 edges.
        add_vec(0, 1, 1, 4'h7, 1, 0, 0, 4'h7, 4'h7, 0, 0);
        for (int i = 0; i < 5; i++)
            add_vec(0, 0, 0, 4'h0, 1, 0, 0, 4'h7, 4'h7, 0, 0);
        // Load 0xF. Load at terminal count beats the wrap.
        add_vec(0, 1, 1, 4'hF, 1, 0, 0, 4'hF, 4'hF, 0, 0);
        add_vec(0, 1, 1, 4'h5, 1, 1, 1, 4'h5, 4'h5, 0, 0);
        add_vec(0, 0, 1, 4'hF, 1, 0, 0, 4'hF, 4'hF, 0, 0);
        // Natural 15->0 wrap, then reset clears the ovf pulse in flight.
        add_vec(0, 1, 0, 4'h0, 1, 1, 1, 4'h0, 4'h0, 1, 1);
        add_vec(1, 1, 0, 4'h0, 1, 0, 0, 4'h0, 4'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].din);
            #1;
            if (vecs[i].chk_tc) begin
                check_val($sformatf("v%0d tc15", i), 8'(tc15), 8'(vecs[i].tc15));
                check_val($sformatf("v%0d tc9", i),  8'(tc9),  8'(vecs[i].tc9));
            end
            @(posedge clk);
            #1;
            check_val($sformatf("v%0d q15", i),   8'(q15),   8'(vecs[i].q15));
            check_val($sformatf("v%0d q9", i),    8'(q9),    8'(vecs[i].q9));
            check_val($sformatf("v%0d ovf15", i), 8'(ovf15), 8'(vecs[i].ovf15));
            check_val($sformatf("v%0d ovf9", i),  8'(ovf9),  8'(vecs[i].ovf9));
        end

        // The idle instances must still show their reset state.
        drive(0, 0, 0, 4'h0);
        #1;
        check_val("reset q1", 8'(q1), 8'h00);
        check_val("reset ovf1", 8'(ovf1), 8'h00);
        check_val("reset cascade", {q_hi, q_lo}, 8'h00);
        check_val("reset tc_lo", 8'(tc_lo), 8'h00);

        // MAX_COUNT=1 with en held: q toggles and ovf is high every second cycle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en1 = 1'b1;
            #1;
            check_val($sformatf("m1 e%0d tc1", i), 8'(tc1), (i % 2 == 1) ? 8'h01 : 8'h00);
            @(posedge clk);
            #1;
            check_val($sformatf("m1 e%0d q1", i),   8'(q1),   (i % 2 == 0) ? 8'h01 : 8'h00);
            check_val($sformatf("m1 e%0d ovf1", i), 8'(ovf1), (i % 2 == 1) ? 8'h01 : 8'h00);
        end
        @(negedge clk);
        en1 = 1'b0;

        // Cascade: 256 enabled edges take {q_hi,q_lo} through 0x00..0xFF and back to 0x00.
        hi_pulses = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            casc_en = 1'b1;
            exp_v = 8'(i + 1);
            exp_q.push_back(exp_v);
            #1;
            check_val($sformatf("casc e%0d tc_lo", i), 8'(tc_lo), (i % 16 == 15) ? 8'h01 : 8'h00);
            check_val($sformatf("casc e%0d tc_hi", i), 8'(tc_hi), (i == 255) ? 8'h01 : 8'h00);
            @(posedge clk);
            #1;
            check_val($sformatf("casc e%0d count", i), {q_hi, q_lo}, exp_q.pop_front());
            check_val($sformatf("casc e%0d ovf_lo", i), 8'(ovf_lo), (i % 16 == 15) ? 8'h01 : 8'h00);
            check_val($sformatf("casc e%0d ovf_hi", i), 8'(ovf_hi), (i == 255) ? 8'h01 : 8'h00);
            if (ovf_hi) hi_pulses++;
        end
        @(negedge clk);
        casc_en = 1'b0;
        check_val("casc hi pulses", 8'(hi_pulses), 8'h01);
        check_val("casc queue drained", 8'(exp_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
